seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 19 +
 rtl/div_abs_neg.sv | 29 ++
 rtl/seq_divider.sv | 197 +++++++++++++++++++
 tb/tb_seq_divider.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider:
//   DIV_WIDTH   - default operand/result width (matches the 16-bit datapath
//                 that the register file presents operands on)
//   div_state_e - divider FSM state encoding
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2,
        DONE   = 2'd3
    } div_state_e;

endpackage : div_pkg

// File: rtl/div_abs_neg.sv
// -----------------------------------------------------------------------------
// div_abs_neg
// Combinational conditional two's-complement negate. This block turns signed
// operands into magnitudes and applies the final signs to the results.
// Ports:
//   a_i   - input value
//   neg_i - 1: output is -a_i (two's complement), 0: output is a_i
//   y_o   - result, same width as a_i
// -----------------------------------------------------------------------------
module div_abs_neg
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] y_o
);

    // Select between pass-through and two's-complement negation.
    always_comb begin
        if (neg_i) begin
            y_o = (~a_i) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            y_o = a_i;
        end
    end

endmodule : div_abs_neg

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle restoring divider, signed or unsigned, one quotient bit per
// cycle MSB-first.
// Ports:
//   clk         - clock, all state changes on the rising edge
//   reset_all   - synchronous active-low reset
//   HALT        - freeze: state, counter, datapath and outputs hold
//   start       - request, accepted only in IDLE while HALT is low
//   is_signed   - 1: two's-complement operands, 0: unsigned (captured w/ start)
//   dividend    - numerator   (captured with start)
//   divisor     - denominator (captured with start)
//   quotient    - registered quotient of the last completed operation
//   remainder   - registered remainder of the last completed operation
//   busy        - high while in DIVIDE or FIX
//   done        - completion pulse (held while HALT keeps the FSM in DONE)
//   div_by_zero - set when the last completed operation had a zero divisor
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_all,
    input  logic             HALT,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int              CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    // FSM and control state
    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             q_neg_q;      // quotient must be negated in FIX
    logic             r_neg_q;      // remainder must be negated in FIX
    logic             div0_q;       // captured divisor was zero

    // Datapath registers
    logic [WIDTH:0]   rem_q;        // partial remainder, one spare bit for carry
    logic [WIDTH-1:0] quo_q;        // dividend magnitude shifting out, quotient in
    logic [WIDTH-1:0] dsr_q;        // divisor magnitude
    logic [WIDTH-1:0] dvd_raw_q;    // unmodified dividend, used for divide-by-zero

    // Registered outputs
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             busy_q;
    logic             done_q;
    logic             div_by_zero_q;

    // Combinational helpers
    logic [WIDTH-1:0] dvd_abs_s;
    logic [WIDTH-1:0] dsr_abs_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;
    logic             dvd_sign_s;
    logic             dsr_sign_s;
    logic [WIDTH+1:0] shift_s;
    logic [WIDTH+1:0] trial_s;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;

    assign dvd_sign_s = is_signed & dividend[WIDTH-1];
    assign dsr_sign_s = is_signed & divisor[WIDTH-1];

    // Operand magnitudes: negative signed operands are negated. The most
    // negative value maps onto itself, which is its correct unsigned magnitude.
    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
        .a_i   (dividend),
        .neg_i (dvd_sign_s),
        .y_o   (dvd_abs_s)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dsr (
        .a_i   (divisor),
        .neg_i (dsr_sign_s),
        .y_o   (dsr_abs_s)
    );

    // Result sign correction applied in FIX.
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .a_i   (quo_q),
        .neg_i (q_neg_q),
        .y_o   (quo_fix_s)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .a_i   (rem_q[WIDTH-1:0]),
        .neg_i (r_neg_q),
        .y_o   (rem_fix_s)
    );

    // One restoring step: shift in the next dividend bit, try to subtract the
    // divisor, keep the difference only if it did not go negative.
    always_comb begin
        shift_s = {rem_q, quo_q[WIDTH-1]};
        trial_s = shift_s - {2'b00, dsr_q};
        if (trial_s[WIDTH+1]) begin
            rem_d = shift_s[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d = trial_s[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end
    end

    // Divider FSM with datapath and registered outputs; HALT freezes all of it.
    always_ff @(posedge clk) begin
        if (!reset_all) begin
            state_q       <= IDLE;
            cnt_q         <= {CNT_W{1'b0}};
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            div0_q        <= 1'b0;
            rem_q         <= {(WIDTH+1){1'b0}};
            quo_q         <= {WIDTH{1'b0}};
            dsr_q         <= {WIDTH{1'b0}};
            dvd_raw_q     <= {WIDTH{1'b0}};
            quotient_q    <= {WIDTH{1'b0}};
            remainder_q   <= {WIDTH{1'b0}};
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else if (!HALT) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q     <= {CNT_W{1'b0}};
                        q_neg_q   <= dvd_sign_s ^ dsr_sign_s;
                        r_neg_q   <= dvd_sign_s;
                        rem_q     <= {(WIDTH+1){1'b0}};
                        quo_q     <= dvd_abs_s;
                        dsr_q     <= dsr_abs_s;
                        dvd_raw_q <= dividend;
                        busy_q    <= 1'b1;
                        // A zero divisor skips the iteration entirely.
                        if (divisor == {WIDTH{1'b0}}) begin
                            div0_q  <= 1'b1;
                            state_q <= FIX;
                        end else begin
                            div0_q  <= 1'b0;
                            state_q <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_STEP) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    if (div0_q) begin
                        quotient_q    <= {WIDTH{1'b1}};
                        remainder_q   <= dvd_raw_q;
                        div_by_zero_q <= 1'b1;
                    end else begin
                        quotient_q    <= quo_fix_s;
                        remainder_q   <= rem_fix_s;
                        div_by_zero_q <= 1'b0;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed + random stimulus for seq_divider. Expected results are pushed to a
// scoreboard queue when an operation is started and popped when done rises.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_all;
    logic         HALT;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_all   (reset_all),
        .HALT        (HALT),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model using plain 32-bit integer arithmetic (truncating division).
    function automatic exp_t model(input logic s, input logic [15:0] a, input logic [15:0] b);
        exp_t m;
        int   sa;
        int   sb;
        int   q;
        int   r;
        if (b == 16'h0000) begin
            m.q = 16'hFFFF; m.r = a; m.dbz = 1'b1; m.lat = 1;
        end else begin
            if (s) begin
                sa = {{16{a[15]}}, a};
                sb = {{16{b[15]}}, b};
            end else begin
                sa = {16'h0000, a};
                sb = {16'h0000, b};
            end
            q = sa / sb;
            r = sa % sb;
            m.q = q[15:0]; m.r = r[15:0]; m.dbz = 1'b0; m.lat = 17;
        end
        return m;
    endfunction

    // Start one operation, wait (bounded) for done, compare against the scoreboard.
    task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                          input int elat, input string tag, input bit halt_in_done);
        exp_t e;
        exp_t got;
        int   n;
        bit   busy_ok;
        e.q = eq; e.r = er; e.dbz = edbz; e.lat = elat;
        sb_q.push_back(e);
        is_signed = s; dividend = a; divisor = b; start = 1'b1;
        tick();
        start = 1'b0; dividend = 16'h0000; divisor = 16'h0000;
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        got = sb_q.pop_front();
        check({tag, " latency"}, n, got.lat);
        check({tag, " quotient"}, quotient, got.q);
        check({tag, " remainder"}, remainder, got.r);
        check({tag, " div_by_zero"}, div_by_zero, got.dbz);
        check({tag, " busy_during"}, busy_ok, 1);
        check({tag, " busy_at_done"}, busy, 0);
        if (halt_in_done) begin
            HALT = 1'b1;
            repeat (3) tick();
            check({tag, " done_held"}, done, 1);
            HALT = 1'b0;
            tick();
            check({tag, " done_after_halt"}, done, 0);
        end else begin
            tick();
            check({tag, " done_pulse"}, done, 0);
        end
        check({tag, " result_hold"}, quotient, got.q);
    endtask

    initial begin
        exp_t m;
        logic s;
        logic [15:0] a;
        logic [15:0] b;
        int   n;
        bit   quiet;

        reset_all = 1'b0; HALT = 1'b0; start = 1'b0; is_signed = 1'b0;
        dividend = 16'h0000; divisor = 16'h0000;
        repeat (2) tick();
        check("rst quotient", quotient, 0);
        check("rst remainder", remainder, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst div_by_zero", div_by_zero, 0);
        reset_all = 1'b1;
        tick();

        run_op(1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, "u100_7", 1'b0);
        run_op(1'b1, 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, 17, "s-7_2", 1'b0);
        run_op(1'b1, 16'd7, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 17, "s7_-2", 1'b0);
        run_op(1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1, "dz", 1'b0);
        run_op(1'b0, 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 17, "u9_3", 1'b0);
        run_op(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17, "ovf", 1'b1);
        run_op(1'b1, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1'b1, 1, "sdz", 1'b0);
        run_op(1'b0, 16'hFFFF, 16'd1, 16'hFFFF, 16'h0000, 1'b0, 17, "umax_1", 1'b0);
        run_op(1'b0, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 17, "u5_9", 1'b0);
        run_op(1'b1, 16'hFF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0, 17, "s-100_-7", 1'b0);

        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom_range(1, 65535));
            if (i == 3) b = 16'($urandom_range(1, 15));
            m = model(s, a, b);
            run_op(s, a, b, m.q, m.r, m.dbz, m.lat, "rand", 1'b0);
        end

        // HALT for 5 cycles mid-DIVIDE, with a second start while busy.
        m = model(1'b0, 16'd100, 16'd7);
        sb_q.push_back(m);
        is_signed = 1'b0; dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        HALT = 1'b1; start = 1'b1; dividend = 16'd50; divisor = 16'd5;
        repeat (5) tick();
        HALT = 1'b0;
        tick();
        start = 1'b0;
        n = 9;
        while (done !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        m = sb_q.pop_front();
        check("halt latency", n, 22);
        check("halt quotient", quotient, m.q);
        check("halt remainder", remainder, m.r);
        tick();
        check("halt done_pulse", done, 0);
        quiet = 1'b1;
        repeat (25) begin
            if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            tick();
        end
        check("halt second_start_ignored", quiet, 1);

        // Reset at DIVIDE cycle 8 abandons the operation.
        is_signed = 1'b0; dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("pre_rst busy", busy, 1);
        reset_all = 1'b0;
        tick();
        check("mid_rst quotient", quotient, 0);
        check("mid_rst remainder", remainder, 0);
        check("mid_rst busy", busy, 0);
        check("mid_rst done", done, 0);
        check("mid_rst div_by_zero", div_by_zero, 0);
        reset_all = 1'b1;
        run_op(1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, "post_rst", 1'b0);

        check("scoreboard empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seq_divider
